// File: rtl/div_scheduler_if.sv
// rtl/div_scheduler_if.sv - requester-side bus of the shared divider scheduler
interface div_scheduler_if #(
    parameter int NREQ = 4,
    parameter int CW   = 22
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] period;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [CW-1:0]      cnt;

    modport master (
        output req, period,
        input  grant, done, busy, cnt
    );

    modport slave (
        input  req, period,
        output grant, done, busy, cnt
    );
endinterface

// File: rtl/div_scheduler.sv
// rtl/div_scheduler.sv - round-robin time-sharing of one down-counter among NREQ requesters; DIVSCHED_ABORT_EN lets the owner withdraw mid-count
module div_scheduler #(
    parameter int NREQ = 4,
    parameter int CW   = 22
) (
    input  logic           clk,
    input  logic           rst,
    div_scheduler_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand_idx;
    int              cand;
    logic [CW-1:0]   win_period;
    logic [NREQ-1:0] owner_onehot;

    // Scan from highest offset down so the last hit is the nearest one after ptr_q.
    always_comb begin : arbiter
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = cand[IW-1:0];
            if (bus.req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin : period_mux
        win_period = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) begin
                win_period = bus.period[i*CW +: CW];
            end
        end
    end

    assign owner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= IW'(NREQ - 1);
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_COUNT;
                    ptr_d   = win_idx;
                    owner_d = win_idx;
                    cnt_d   = (win_period == '0) ? CW'(1) : win_period;
                end
            end
            S_COUNT: begin
`ifdef DIVSCHED_ABORT_EN
                // Pointer stays on the withdrawn owner so fairness keeps advancing.
                if (!bus.req[owner_q]) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else
`endif
                if (cnt_q <= CW'(1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin : outputs
        bus.grant = '0;
        bus.done  = '0;
        bus.busy  = 1'b0;
        case (state_q)
            S_COUNT: begin
                bus.grant = owner_onehot;
                bus.busy  = 1'b1;
            end
            S_DONE: begin
                bus.done = owner_onehot;
                bus.busy = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.cnt = cnt_q;
endmodule

// File: tb/tb_div_scheduler.sv
// tb/tb_div_scheduler.sv - directed and randomized checks of div_scheduler against a round-robin service model
module tb_div_scheduler;
    localparam int NREQ = 4;
    localparam int CW   = 10;
    localparam int PMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_ptr;
    int   per [NREQ];
    int   w;

    always #5 clk = ~clk;

    div_scheduler_if #(.NREQ(NREQ), .CW(CW)) bus ();

    div_scheduler #(.NREQ(NREQ), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    function automatic logic [31:0] oh(input int i);
        return 32'(1) << i;
    endfunction

    // Round-robin rule: first set request scanning cyclically after the last winner.
    function automatic int rr_pick(input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_period(input int i, input int p);
        per[i] = p;
        bus.period[i*CW +: CW] = CW'(p);
    endtask

    task automatic run_cnt(input int o, input int hi, input int lo);
        for (int v = hi; v >= lo; v--) begin
            chk("count_grant", 32'(bus.grant), oh(o));
            chk("count_cnt", 32'(bus.cnt), 32'(v));
            chk("count_busy", 32'(bus.busy), 32'(1));
            chk("count_done", 32'(bus.done), 32'(0));
            step();
        end
    endtask

    task automatic expect_done(input int o);
        chk("done_grant", 32'(bus.grant), 32'(0));
        chk("done_pulse", 32'(bus.done), oh(o));
        chk("done_busy", 32'(bus.busy), 32'(1));
        chk("done_cnt", 32'(bus.cnt), 32'(0));
        step();
        chk("idle_busy", 32'(bus.busy), 32'(0));
        chk("idle_grant", 32'(bus.grant), 32'(0));
        chk("idle_done", 32'(bus.done), 32'(0));
        chk("idle_cnt", 32'(bus.cnt), 32'(0));
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_grant"}, 32'(bus.grant), 32'(0));
        chk({tag, "_done"}, 32'(bus.done), 32'(0));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
        chk({tag, "_cnt"}, 32'(bus.cnt), 32'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        check_quiet("reset");
        rst   = 1'b0;
        m_ptr = NREQ - 1;
    endtask

    task automatic serve();
        w = rr_pick(bus.req);
        m_ptr = w;
        step();
        run_cnt(w, eff(per[w]), 1);
        expect_done(w);
    endtask

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.period = '0;
        for (int i = 0; i < NREQ; i++) per[i] = 0;

        // single request
        do_reset();
        bus.req = 4'b0001;
        set_period(0, 5);
        serve();
        bus.req = '0;
        step();
        check_quiet("idle_noreq");

        // round-robin with all requesters held
        do_reset();
        bus.req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_period(i, 2);
        for (int s = 0; s < 5; s++) serve();
        bus.req = '0;
        step();

        // period edge values including full scale
        do_reset();
        bus.req = 4'b0001;
        set_period(0, 0);
        serve();
        set_period(0, 1);
        serve();
        set_period(0, PMAX);
        serve();
        bus.req = '0;
        step();

        // reset in the middle of a count
        do_reset();
        bus.req = 4'b0010;
        set_period(1, 10);
        w = rr_pick(bus.req);
        m_ptr = w;
        step();
        run_cnt(w, 10, 7);
        chk("midrst_cnt6", 32'(bus.cnt), 32'(6));
        rst = 1'b1;
        step();
        check_quiet("midrst");
        rst = 1'b0;
        m_ptr = NREQ - 1;
        bus.req = 4'b0110;
        set_period(1, 3);
        serve();
        bus.req = '0;
        step();

        // owner withdraws mid-count
        bus.req = 4'b0100;
        set_period(2, 8);
        w = rr_pick(bus.req);
        m_ptr = w;
        step();
        run_cnt(w, 8, 5);
        chk("wd_cnt4", 32'(bus.cnt), 32'(4));
        bus.req = '0;
        step();
`ifdef DIVSCHED_ABORT_EN
        check_quiet("abort");
        for (int s = 0; s < 3; s++) begin
            step();
            check_quiet("abort_after");
        end
`else
        run_cnt(w, 3, 1);
        expect_done(w);
`endif

        // late request and period change while counting
        bus.req = 4'b0001;
        set_period(0, 6);
        set_period(3, 3);
        w = rr_pick(bus.req);
        m_ptr = w;
        step();
        run_cnt(w, 6, 5);
        bus.req = 4'b1001;
        set_period(0, 20);
        run_cnt(w, 4, 1);
        expect_done(w);
        set_period(3, 7);
        serve();
        serve();
        bus.req = '0;
        step();

        // randomized requests and periods
        do_reset();
        for (int it = 0; it < 40; it++) begin
            bus.req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) set_period(i, int'($urandom_range(0, 12)));
            if (bus.req == '0) begin
                step();
                check_quiet("rand_idle");
            end else begin
                serve();
            end
        end
        bus.req = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
